hanoi_display_capture: RTL



---
 rtl/hanoi_display_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hanoi_display_capture.sv
// Passive readback of the Hanoi multiplexed 7-segment display: filters and decodes digits,
// rebuilds four-slot frames, and reports the recovered board, win banner and legality.
module hanoi_display_capture #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned BLANK_TIMEOUT = 1_000_000
) (
    input  logic       msclk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic [3:0] peg0,
    output logic [3:0] peg1,
    output logic [3:0] peg2,
    output logic [3:0] peg3,
    output logic       win,
    output logic       frame_valid,
    output logic       legal,
    output logic       blank,
    output logic [7:0] glyph_err
);

    localparam logic [7:0] StabMax = 8'(STABLE_CYCLES);
    localparam logic [7:0] StabAcc = 8'(STABLE_CYCLES - 2);
    localparam int unsigned BlankW = $clog2(BLANK_TIMEOUT + 1);
    localparam logic [BlankW-1:0] BlankMax = BlankW'(BLANK_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

    logic [11:0]       samp_q, prev_q;
    logic [7:0]        stab_q;
    logic              match;
    logic              slot_ok;
    logic [1:0]        slot;
    logic              accept;
    logic [7:0]        ban_glyph;
    logic              disk_ok, is_banner, bad;
    logic [3:0]        nib;
    logic [BlankW-1:0] blank_cnt_q;

    state_e            state_q;
    logic [3:0]        seen_q;
    logic              dirty_q;
    logic [3:0][3:0]   stage_nib_q;
    logic [3:0]        stage_ban_q;
    logic              mixed, legal_c;
    logic [3:0]        or_all, overlap;

    // samp_q is the compare stage; a digit counts only once it matches its own previous sample
    assign match  = (samp_q == prev_q);
    assign accept = match && (stab_q == StabAcc) && slot_ok;

    always_ff @(posedge msclk or posedge rst) begin
        if (rst) begin
            samp_q <= 12'hFFF;
            prev_q <= 12'hFFF;
            stab_q <= 8'd0;
        end else begin
            samp_q <= {an, seg};
            prev_q <= samp_q;
            if (!match) begin
                stab_q <= 8'd0;
            end else if (stab_q != StabMax) begin
                stab_q <= stab_q + 8'd1;
            end
        end
    end

    always_comb begin
        slot_ok = 1'b1;
        slot    = 2'd0;
        case (samp_q[11:8])
            4'b0111: slot = 2'd0;
            4'b1110: slot = 2'd1;
            4'b1101: slot = 2'd2;
            4'b1011: slot = 2'd3;
            default: slot_ok = 1'b0;
        endcase
    end

    always_comb begin
        ban_glyph = 8'b10001001;
        case (slot)
            2'd0: ban_glyph = 8'b10001001;
            2'd1: ban_glyph = 8'b10001000;
            2'd2: ban_glyph = 8'b10000110;
            2'd3: ban_glyph = 8'b10010001;
            default: ban_glyph = 8'b10001001;
        endcase
    end

    assign disk_ok   = samp_q[5] & samp_q[4] & samp_q[2] & samp_q[1];
    assign nib       = {~samp_q[7], ~samp_q[3], ~samp_q[6], ~samp_q[0]};
    assign is_banner = (samp_q[7:0] == ban_glyph);
    assign bad       = !disk_ok && !is_banner;

    always_comb begin
        or_all  = stage_nib_q[0] | stage_nib_q[1] | stage_nib_q[2] | stage_nib_q[3];
        overlap = (stage_nib_q[0] & stage_nib_q[1]) | (stage_nib_q[0] & stage_nib_q[2])
                | (stage_nib_q[0] & stage_nib_q[3]) | (stage_nib_q[1] & stage_nib_q[2])
                | (stage_nib_q[1] & stage_nib_q[3]) | (stage_nib_q[2] & stage_nib_q[3]);
        legal_c = (or_all == 4'hF) && (overlap == 4'h0);
        // Banner and disk digits in one frame cannot describe a real game state
        mixed   = (|stage_ban_q) && !(&stage_ban_q);
    end

    always_ff @(posedge msclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            seen_q      <= 4'h0;
            dirty_q     <= 1'b0;
            stage_nib_q <= '0;
            stage_ban_q <= 4'h0;
            peg0        <= 4'h0;
            peg1        <= 4'h0;
            peg2        <= 4'h0;
            peg3        <= 4'h0;
            win         <= 1'b0;
            legal       <= 1'b0;
            frame_valid <= 1'b0;
            glyph_err   <= 8'd0;
        end else begin
            frame_valid <= 1'b0;
            if (accept) begin
                stage_nib_q[slot] <= disk_ok ? nib : 4'h0;
                stage_ban_q[slot] <= is_banner;
                seen_q[slot]      <= 1'b1;
                if (bad) begin
                    dirty_q <= 1'b1;
                    if (glyph_err != 8'hFF) glyph_err <= glyph_err + 8'd1;
                end
            end
            case (state_q)
                StIdle: if (accept) state_q <= StFill;
                StFill: if (seen_q == 4'hF) state_q <= StCommit;
                StCommit: begin
                    if (!dirty_q && !mixed) begin
                        peg0        <= stage_nib_q[0];
                        peg1        <= stage_nib_q[1];
                        peg2        <= stage_nib_q[2];
                        peg3        <= stage_nib_q[3];
                        win         <= &stage_ban_q;
                        legal       <= legal_c;
                        frame_valid <= 1'b1;
                    end
                    // A digit landing on the commit cycle opens the next frame
                    seen_q  <= accept ? (4'b0001 << slot) : 4'h0;
                    dirty_q <= accept && bad;
                    state_q <= accept ? StFill : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge msclk or posedge rst) begin
        if (rst) begin
            blank_cnt_q <= '0;
            blank       <= 1'b0;
        end else if (samp_q[11:8] != 4'b1111) begin
            blank_cnt_q <= '0;
            blank       <= 1'b0;
        end else begin
            if (blank_cnt_q != BlankMax) blank_cnt_q <= blank_cnt_q + 1'b1;
            blank <= (blank_cnt_q >= BlankMax - 1'b1);
        end
    end

endmodule
